// File: rtl/gen_senales_pkg.sv
// Shared types and constants for the RTC bus-cycle generator.
package gen_senales_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_SU,
    ST_ADDR_PW,
    ST_ADDR_HD,
    ST_GAP1,
    ST_DATA_SU,
    ST_DATA_PW,
    ST_DATA_HD,
    ST_GAP2
  } estado_t;

  localparam logic [7:0] PORT_CMD_DEF  = 8'h10;
  localparam logic [7:0] PORT_ADDR_DEF = 8'h11;
  localparam logic [7:0] PORT_DATA_DEF = 8'h12;

  localparam int unsigned CMD_START   = 0;
  localparam int unsigned CMD_DIR     = 1;
  localparam int unsigned CMD_LEN_LSB = 2;
  localparam int unsigned CMD_LEN_MSB = 5;
  localparam int unsigned CMD_CLR_ERR = 7;

  localparam int unsigned LEN_W  = CMD_LEN_MSB - CMD_LEN_LSB + 1;
  localparam int unsigned CONT_W = 5;

endpackage

// File: rtl/fifo_escritura.sv
// Synchronous write-data FIFO; a pop in the same cycle frees room for a push when full.
module fifo_escritura #(
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          reloj,
  input  logic                          resetM,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DW-1:0]                 din,
  output logic [DW-1:0]                 dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LLENO = (AW+1)'(FIFO_DEPTH);

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != LLENO) || w_pop);

  always_ff @(posedge reloj) begin
    if (!resetM) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge reloj) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == LLENO);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/gen_ciclo_bus.sv
// Multiplexed address/data RTC bus-cycle generator driven by PicoBlaze port writes.
// Supports bursts with address auto-increment, a write FIFO and read capture.
module gen_ciclo_bus
  import gen_senales_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_PULSE    = 4,
  parameter int unsigned T_HOLD     = 2,
  parameter int unsigned T_GAP      = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  PORT_CMD   = PORT_CMD_DEF,
  parameter logic [7:0]  PORT_ADDR  = PORT_ADDR_DEF,
  parameter logic [7:0]  PORT_DATA  = PORT_DATA_DEF
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              en_01,
  input  logic [7:0]        port_id,
  input  logic [DW-1:0]     out_port,
  input  logic [DW-1:0]     bus_in,
  output logic [DW-1:0]     bus_out,
  output logic              bus_oe,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic              A_D,
  output logic              LE,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              error,
  output logic [CONT_W-1:0] cont_fase
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  estado_t           r_state, w_nxt;
  logic [CONT_W-1:0] r_cont, w_cont_nxt;
  logic [DW-1:0]     r_addr, r_addr_sh, w_addr_nxt;
  logic [LEN_W-1:0]  r_words, w_len_m1;
  logic              r_dir;
  logic              r_cs, r_rd, r_wr, r_ad, r_oe, r_le, r_rd_valid, r_busy, r_error;
  logic [DW-1:0]     r_bus, r_rd_data, w_fifo_dout;
  logic [CNT_W-1:0]  w_count;
  logic w_wr_cmd, w_wr_addr, w_wr_data, w_start, w_dir_cmd, w_clr;
  logic w_idle, w_fin, w_short, w_accept, w_err_set, w_push, w_pop, w_full, w_empty;
  logic w_addr_ph, w_data_ph, w_capt;

  // Last cycle index of the current phase
  function automatic logic [CONT_W-1:0] fin_cont(input estado_t s);
    case (s)
      ST_ADDR_SU, ST_DATA_SU: fin_cont = CONT_W'(T_SETUP - 1);
      ST_ADDR_PW, ST_DATA_PW: fin_cont = CONT_W'(T_PULSE - 1);
      ST_ADDR_HD, ST_DATA_HD: fin_cont = CONT_W'(T_HOLD - 1);
      ST_GAP1, ST_GAP2:       fin_cont = CONT_W'(T_GAP - 1);
      default:                fin_cont = '0;
    endcase
  endfunction

  assign w_wr_cmd  = en_01 && (port_id == PORT_CMD);
  assign w_wr_addr = en_01 && (port_id == PORT_ADDR);
  assign w_wr_data = en_01 && (port_id == PORT_DATA);
  assign w_start   = w_wr_cmd && out_port[CMD_START];
  assign w_dir_cmd = out_port[CMD_DIR];
  assign w_clr     = w_wr_cmd && out_port[CMD_CLR_ERR];
  assign w_len_m1  = out_port[CMD_LEN_MSB:CMD_LEN_LSB];

  assign w_idle    = (r_state == ST_IDLE);
  assign w_fin     = (r_cont == fin_cont(r_state));
  assign w_short   = !w_dir_cmd && (w_count < CNT_W'({1'b0, w_len_m1} + (LEN_W+1)'(1)));
  assign w_accept  = w_start && w_idle && !w_short;
  assign w_pop     = (r_state == ST_DATA_HD) && w_fin && !r_dir && !w_empty;
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_err_set = (w_start && !w_idle) || (w_start && w_idle && w_short)
                   || (w_wr_data && w_full && !w_pop);
  assign w_capt    = (r_state == ST_DATA_PW) && w_fin && r_dir;

  fifo_escritura #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .reloj (reloj),
    .resetM(resetM),
    .push  (w_push),
    .pop   (w_pop),
    .din   (out_port),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Phase sequencing; the working address advances on leaving GAP2 with words left
  always_comb begin
    w_nxt      = r_state;
    w_cont_nxt = r_cont;
    w_addr_nxt = r_addr;
    if (r_state == ST_IDLE) begin
      if (w_accept) begin
        w_nxt      = ST_ADDR_SU;
        w_addr_nxt = r_addr_sh;
      end
    end else if (w_fin) begin
      w_cont_nxt = '0;
      case (r_state)
        ST_ADDR_SU: w_nxt = ST_ADDR_PW;
        ST_ADDR_PW: w_nxt = ST_ADDR_HD;
        ST_ADDR_HD: w_nxt = ST_GAP1;
        ST_GAP1:    w_nxt = ST_DATA_SU;
        ST_DATA_SU: w_nxt = ST_DATA_PW;
        ST_DATA_PW: w_nxt = ST_DATA_HD;
        ST_DATA_HD: w_nxt = ST_GAP2;
        ST_GAP2: begin
          if (r_words != '0) begin
            w_nxt      = ST_ADDR_SU;
            w_addr_nxt = r_addr + DW'(1);
          end else begin
            w_nxt = ST_IDLE;
          end
        end
        default:    w_nxt = ST_IDLE;
      endcase
    end else begin
      w_cont_nxt = r_cont + CONT_W'(1);
    end
  end

  assign w_addr_ph = w_nxt inside {ST_ADDR_SU, ST_ADDR_PW, ST_ADDR_HD};
  assign w_data_ph = w_nxt inside {ST_DATA_SU, ST_DATA_PW, ST_DATA_HD};

  // State plus pin outputs, decoded from the upcoming state so pins change with it
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      r_state    <= ST_IDLE;
      r_cont     <= '0;
      r_addr     <= '0;
      r_addr_sh  <= '0;
      r_words    <= '0;
      r_dir      <= 1'b0;
      r_cs       <= 1'b1;
      r_rd       <= 1'b1;
      r_wr       <= 1'b1;
      r_ad       <= 1'b1;
      r_oe       <= 1'b0;
      r_bus      <= '0;
      r_le       <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cont  <= w_cont_nxt;
      r_addr  <= w_addr_nxt;
      if (w_wr_addr) r_addr_sh <= out_port;
      if (w_accept) begin
        r_dir   <= w_dir_cmd;
        r_words <= w_len_m1;
      end else if ((r_state == ST_GAP2) && w_fin && (r_words != '0)) begin
        r_words <= r_words - LEN_W'(1);
      end
      r_cs   <= !(w_addr_ph || w_data_ph);
      r_ad   <= !w_addr_ph;
      r_wr   <= !((w_nxt == ST_ADDR_PW) || ((w_nxt == ST_DATA_PW) && !r_dir));
      r_rd   <= !((w_nxt == ST_DATA_PW) && r_dir);
      r_oe   <= w_addr_ph || (w_data_ph && !r_dir);
      r_bus  <= w_addr_ph ? w_addr_nxt : ((w_data_ph && !r_dir) ? w_fifo_dout : '0);
      r_le   <= (w_nxt == ST_DATA_PW) && (w_cont_nxt == CONT_W'(T_PULSE - 1)) && r_dir;
      if (w_capt) r_rd_data <= bus_in;
      r_rd_valid <= w_capt;
      r_busy     <= (w_nxt != ST_IDLE);
      r_error    <= (r_error && !w_clr) || w_err_set;
    end
  end

  assign bus_out   = r_bus;
  assign bus_oe    = r_oe;
  assign CS        = r_cs;
  assign RD        = r_rd;
  assign WR        = r_wr;
  assign A_D       = r_ad;
  assign LE        = r_le;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign busy      = r_busy;
  assign error     = r_error;
  assign cont_fase = r_cont;

endmodule

// File: doc/gen_ciclo_bus.md
Name: gen_ciclo_bus

Overview:
- Parametrised bus-cycle generator for the multiplexed address/data RTC interface.
- Generalises the fixed-timing signal generator:
  - configurable phase timing and data width;
  - burst transfers of 1–16 words with address auto-increment;
  - write-data FIFO loaded from PicoBlaze;
  - read capture with valid pulse;
  - busy/error status.
- Sits between PicoBlaze port writes (en_01/port_id/out_port) and the RTC pins (CS, RD, WR, A_D, data bus).

Parameters:
- DW, 8, data/address bus width.
- T_SETUP, 2, cycles CS/A_D/bus valid before a strobe (≥1).
- T_PULSE, 4, cycles WR or RD held low (≥1).
- T_HOLD, 2, cycles after strobe rise before CS rises (≥1).
- T_GAP, 2, cycles CS high between phases and between burst words (≥1).
- FIFO_DEPTH, 16, write-data FIFO entries (power of 2, ≥16).
- PORT_CMD, 8'h10, command port id.
- PORT_ADDR, 8'h11, start-address port id.
- PORT_DATA, 8'h12, write-data FIFO push port id.

Ports:
- reloj  in  1  system clock, all logic rising edge.
- resetM  in  1  synchronous, active-low reset.
- en_01  in  1  PicoBlaze write strobe (qualifies port_id/out_port).
- port_id  in  8  PicoBlaze port id.
- out_port  in  DW  PicoBlaze write data.
- bus_in  in  DW  data sampled from RTC bus.
- bus_out  out  DW  data/address driven to RTC bus.
- bus_oe  out  1  tristate enable for bus_out.
- CS, RD, WR, A_D  out  1 each  RTC strobes, active-low except A_D (0=address, 1=data).
- LE  out  1  one-cycle read-latch pulse.
- rd_data  out  DW  last captured read word.
- rd_valid  out  1  one-cycle pulse, rd_data updated.
- busy  out  1  transaction in progress.
- error  out  1  sticky error flag.
- cont_fase  out  5  phase cycle counter (debug).

Behaviour:
- Reset: on resetM=0 at a rising edge, next state is:
  - IDLE; CS=RD=WR=A_D=1; bus_oe=0; bus_out=0;
  - LE=rd_valid=busy=error=0; rd_data=0; cont_fase=0;
  - FIFO emptied; address register=0.
  - Applies mid-transaction: transaction is abandoned, no further strobes.
- Port writes (en_01=1):
  - PORT_ADDR: loads address shadow.
  - PORT_DATA: pushes out_port. If FIFO full, the word is dropped and error is set.
  - PORT_CMD fields:
    - bit0 start;
    - bit1 dir (1=read);
    - bits[5:2] len-1;
    - bit7 clear error.
    - Clear applies same cycle; a start in the same write still evaluates.
- Start is accepted only in IDLE. Start while busy is ignored and sets error.
- Write start with FIFO count < len: ignored, sets error.
- Accept: working address ← shadow, word counter ← len-1, busy=1 next cycle.
- FSM per word; cont_fase counts 0..T_x-1 within each state:
  - ADDR_SU (T_SETUP): CS=0, A_D=0, bus_oe=1, bus_out=addr.
  - ADDR_PW (T_PULSE): also WR=0.
  - ADDR_HD (T_HOLD): WR=1.
  - GAP1 (T_GAP): CS=1, bus_oe=0.
  - DATA_SU (T_SETUP): CS=0, A_D=1. On write: bus_oe=1, bus_out=FIFO head.
  - DATA_PW (T_PULSE): RD=0 if read, else WR=0.
  - DATA_HD (T_HOLD): strobes high.
  - On write, FIFO pops on the last DATA_HD cycle.
  - GAP2 (T_GAP): CS=1, A_D=1, bus_oe=0.
    - Then, if words remain: addr+1 (wraps 2^DW-1→0), next ADDR_SU.
    - Otherwise IDLE; busy=0 in the IDLE cycle.
- Read capture: LE=1 on the last DATA_PW cycle; rd_data←bus_in at that edge; rd_valid=1 the following cycle.
- Cycles per word: 2·(T_SETUP+T_PULSE+T_HOLD)+2·T_GAP (default 20).
- A new start is accepted from the first IDLE cycle.
- FIFO push+pop same cycle: count unchanged, push allowed even when full.
- PORT_ADDR writes while busy only affect the shadow.
- PORT_DATA pushes while busy are allowed.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package gen_senales_pkg:
  - FSM state enum;
  - default port-id constants;
  - CMD bit positions (START, DIR, LEN_LSB/MSB, CLR_ERR).
- Sub-module fifo_escritura: sync FIFO, params DW/FIFO_DEPTH; ports push, pop, din, dout, full, empty, count.

Test Plan:
- Reset: resetM=0 for 3 cycles mid-burst → next edge CS=RD=WR=A_D=1, busy=0, bus_oe=0, FIFO count 0; no strobe afterwards.
- Single write: ADDR=0x21, DATA=0x45, CMD=0x01.
  - Address phase: CS low 8 cycles, A_D=0, bus_out=0x21, WR low cycles 3–6.
  - Data phase: CS low 8 cycles with A_D=1, bus_out=0x45, WR low 4 cycles.
  - busy high 20 cycles.
- Burst read: ADDR=0xFE, CMD=0x0B (len 3, read), bus_in model returns addr^0x5A.
  - Addresses driven 0xFE, 0xFF, 0x00.
  - rd_valid pulses 3× with rd_data 0xA4, 0xA5, 0x5A.
  - LE coincident with last RD-low cycle.
- Underflow/busy errors:
  - push 1 word, CMD=0x05 (write len 2) → no CS activity, error=1.
  - CMD=0x80 → error=0.
  - Start during burst → ignored, error=1.
- FIFO full: push 17 words with FIFO_DEPTH=16 → count 16, error=1; burst write len 16 drives the first 16 words in order.
- Timing param: instance T_SETUP=1, T_PULSE=2, T_HOLD=1, T_GAP=1 → 10 cycles per word, strobe widths 2 cycles.
